// File: rtl/status_led_sequencer_if.sv
// Control/status bundle between the decryption-core cluster and the LED sequencer.
// The master drives search control and core status; the slave (sequencer) drives the LEDs.
interface status_led_sequencer_if #(
  parameter int NUM_CORES = 4,
  parameter int NUM_LEDS  = 10,
  parameter int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
);
  logic                 start;
  logic                 clear;
  logic [NUM_CORES-1:0] core_success;
  logic [NUM_CORES-1:0] core_fail;
  logic [NUM_LEDS-1:0]  LEDR;
  logic [CORE_W-1:0]    winner;
  logic [1:0]           state_out;

  modport master (
    output start, clear, core_success, core_fail,
    input  LEDR, winner, state_out
  );

  modport slave (
    input  start, clear, core_success, core_fail,
    output LEDR, winner, state_out
  );
endinterface

// File: rtl/status_led_sequencer.sv
// Clocked LED status sequencer for a multi-core RC4 key search: chaser while searching,
// solid winner on success, blinking bank on failure. Outputs decode from registers only.
module status_led_sequencer #(
  parameter int NUM_CORES = 4,
  parameter int NUM_LEDS  = 10,
  parameter int TICK_DIV  = 25000000,
  parameter int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input logic                   clk,
  input logic                   reset,
  status_led_sequencer_if.slave bus
);
  localparam int CHASE_LEN = NUM_LEDS - NUM_CORES;
  localparam int POS_W     = (CHASE_LEN > 1) ? $clog2(CHASE_LEN) : 1;
  localparam int CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_SEARCH  = 2'b01,
    S_SUCCESS = 2'b10,
    S_FAILURE = 2'b11
  } state_t;

  state_t               state, state_d;
  logic [NUM_CORES-1:0] fail_mask, fail_mask_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [POS_W-1:0]     pos, pos_d;
  logic                 blink, blink_d;
  logic [CORE_W-1:0]    winner_q, winner_d, lowest;
  logic [NUM_LEDS-1:0]  leds;
  logic                 tick;

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  // Lowest-numbered successful core wins when several report in the same cycle.
  always_comb begin
    lowest = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (bus.core_success[i]) lowest = CORE_W'(i);
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state;
    fail_mask_d = fail_mask;
    cnt_d       = tick ? '0 : cnt + 1'b1;
    pos_d       = pos;
    blink_d     = blink;
    winner_d    = winner_q;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_SEARCH;
          fail_mask_d = '0;
        end
      end
      S_SEARCH: begin
        fail_mask_d = fail_mask | bus.core_fail;
        if (tick) pos_d = (pos == POS_W'(CHASE_LEN - 1)) ? '0 : pos + 1'b1;
        if (|bus.core_success) begin
          state_d  = S_SUCCESS;
          winner_d = lowest;
        end else if (&fail_mask_d) begin
          state_d = S_FAILURE;
        end
      end
      S_FAILURE: begin
        if (tick) blink_d = ~blink;
      end
      default: ;
    endcase

    if (bus.clear) begin
      state_d     = S_IDLE;
      fail_mask_d = '0;
      winner_d    = '0;
    end

    // Every state entry restarts the animation from its first frame.
    if (state_d != state) begin
      cnt_d   = '0;
      pos_d   = '0;
      blink_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      fail_mask <= '0;
      cnt       <= '0;
      pos       <= '0;
      blink     <= 1'b1;
      winner_q  <= '0;
    end else begin
      state     <= state_d;
      fail_mask <= fail_mask_d;
      cnt       <= cnt_d;
      pos       <= pos_d;
      blink     <= blink_d;
      winner_q  <= winner_d;
    end
  end

  always_comb begin
    leds = '0;
    case (state)
      S_SEARCH: begin
        leds[NUM_CORES-1:0] = fail_mask;
        for (int i = 0; i < CHASE_LEN; i++) begin
          leds[NUM_CORES + i] = (pos == POS_W'(i));
        end
      end
      S_SUCCESS: begin
        for (int i = 0; i < NUM_CORES; i++) begin
          leds[i] = (winner_q == CORE_W'(i));
        end
        leds[NUM_LEDS-1:NUM_CORES] = '1;
      end
      S_FAILURE: leds = {NUM_LEDS{blink}};
      default:   leds = '0;
    endcase
  end

  assign bus.LEDR      = leds;
  assign bus.state_out = state;
  assign bus.winner    = (state == S_SUCCESS) ? winner_q : '0;
endmodule

// File: tb/tb_status_led_sequencer.sv
// Scoreboard bench for status_led_sequencer: stimulus pushes model predictions per clock,
// a negedge monitor pops and compares them against the LED bank, winner and state.
module tb_status_led_sequencer;
  localparam int NC    = 4;
  localparam int NL    = 10;
  localparam int TD    = 4;
  localparam int CW    = 2;
  localparam int CHASE = NL - NC;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  status_led_sequencer_if #(.NUM_CORES(NC), .NUM_LEDS(NL), .CORE_W(CW)) bus ();

  status_led_sequencer #(
    .NUM_CORES(NC), .NUM_LEDS(NL), .TICK_DIV(TD), .CORE_W(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]    st;
    logic [CW-1:0] win;
    logic [NL-1:0] led;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: mode 0..3, set of exhausted cores, cycles spent in the current mode.
  int          m_mode  = 0;
  int          m_cyc   = 0;
  int          m_win   = 0;
  logic [NC-1:0] m_fails = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, req);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.st  = 2'(m_mode);
    e.win = (m_mode == 2) ? CW'(m_win) : '0;
    e.led = '0;
    case (m_mode)
      1: begin
        e.led[NC-1:0] = m_fails;
        e.led[NC + (m_cyc / TD) % CHASE] = 1'b1;
      end
      2: begin
        e.led[m_win]   = 1'b1;
        e.led[NL-1:NC] = '1;
      end
      3: e.led = (((m_cyc / TD) % 2) == 0) ? '1 : '0;
      default: ;
    endcase
    return e;
  endfunction

  task automatic model_step();
    if (bus.clear) begin
      m_mode = 0; m_fails = '0; m_win = 0; m_cyc = 0;
    end else begin
      case (m_mode)
        0: if (bus.start) begin m_mode = 1; m_fails = '0; m_cyc = 0; end
        1: begin
          m_fails = m_fails | bus.core_fail;
          if (bus.core_success != '0) begin
            m_mode = 2;
            m_cyc  = 0;
            for (int i = 0; i < NC; i++) begin
              if (bus.core_success[i]) begin m_win = i; break; end
            end
          end else if (m_fails == '1) begin
            m_mode = 3;
            m_cyc  = 0;
          end else begin
            m_cyc++;
          end
        end
        default: m_cyc++;
      endcase
    end
  endtask

  task automatic drive(input logic s, input logic c, input logic [NC-1:0] f, input logic [NC-1:0] su);
    bus.start        = s;
    bus.clear        = c;
    bus.core_fail    = f;
    bus.core_success = su;
  endtask

  // Called at negedge+1: predict the next edge, then wait until just after the following negedge.
  task automatic cycle();
    model_step();
    exp_q.push_back(model_out());
    @(negedge clk);
    #1;
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_led", bus.LEDR, 0);
    check("rst_state", bus.state_out, 0);
    check("rst_winner", bus.winner, 0);
    m_mode = 0; m_fails = '0; m_win = 0; m_cyc = 0;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("led", bus.LEDR, e.led);
        check("state", bus.state_out, e.st);
        check("winner", bus.winner, e.win);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    drive(0, 0, '0, '0);
    async_reset();

    // Core activity in IDLE is ignored.
    drive(0, 0, 4'b1111, 4'b1111);
    repeat (3) cycle();
    drive(0, 0, '0, '0);
    cycle();

    // Chaser start, first advance and wrap.
    drive(1, 0, '0, '0);
    cycle();
    check("search_entry_led", bus.LEDR, 10'b0000010000);
    check("search_entry_state", bus.state_out, 2'b01);
    drive(0, 0, '0, '0);
    repeat (4) cycle();
    check("chaser_step", bus.LEDR, 10'b0000100000);
    repeat (20) cycle();
    check("chaser_wrap", bus.LEDR, 10'b0000010000);

    // Success with lowest winner, then sticky.
    drive(0, 0, 4'b0010, '0);
    cycle();
    drive(0, 0, '0, 4'b1100);
    cycle();
    check("succ_led", bus.LEDR, 10'b1111110100);
    check("succ_winner", bus.winner, 2);
    drive(0, 0, 4'b1111, 4'b0011); cycle();
    drive(0, 0, '0, '0);           cycle();
    drive(0, 0, '0, 4'b1111);      cycle();
    check("succ_sticky", bus.LEDR, 10'b1111110100);
    drive(0, 1, '0, '0);
    cycle();
    check("clear_led", bus.LEDR, 0);

    // Success beats the final fail bit.
    drive(1, 0, '0, '0);     cycle();
    drive(0, 0, 4'b0001, '0); cycle();
    drive(0, 0, '0, '0);      cycle();
    drive(0, 0, 4'b0010, '0); cycle();
    drive(0, 0, 4'b0100, '0); cycle();
    drive(0, 0, 4'b1000, 4'b1000); cycle();
    check("prio_state", bus.state_out, 2'b10);
    check("prio_winner", bus.winner, 3);
    drive(0, 1, '0, '0); cycle();

    // Failure blink and clear.
    drive(1, 0, '0, '0);      cycle();
    drive(0, 0, 4'b1111, '0); cycle();
    check("fail_on", bus.LEDR, 10'h3FF);
    check("fail_state", bus.state_out, 2'b11);
    drive(0, 0, '0, '0);
    repeat (4) cycle();
    check("fail_off", bus.LEDR, 10'h000);
    repeat (4) cycle();
    check("fail_on_again", bus.LEDR, 10'h3FF);
    drive(0, 1, '0, '0); cycle();
    check("fail_clear_state", bus.state_out, 2'b00);

    // clear beats start; reset mid-search clears the mask.
    drive(1, 1, '0, '0); cycle();
    check("start_clear_idle", bus.state_out, 2'b00);
    drive(1, 0, '0, '0);      cycle();
    drive(0, 0, 4'b0011, '0); cycle();
    drive(0, 0, '0, '0);
    repeat (2) cycle();
    async_reset();
    drive(1, 0, '0, '0); cycle();
    check("mask_after_reset", bus.LEDR, 10'b0000010000);
    drive(0, 0, '0, '0); cycle();

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      logic [NC-1:0] f;
      logic [NC-1:0] su;
      su = bus.core_success;
      for (int b = 0; b < NC; b++) f[b] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 29) == 0) su = NC'($urandom_range(0, 15));
      else if ($urandom_range(0, 9) == 0) su = '0;
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0, f, su);
      if ($urandom_range(0, 249) == 0) async_reset();
      else cycle();
    end

    drive(0, 0, '0, '0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
